// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: sequential / jump / jalr / trap next-PC with buffering of stalled redirects.
// Optional feature macro: PC_GEN_RVC_EN (adds inst_len2, 2-byte step and 2-byte jump alignment).
module pc_gen #(
  parameter int          XLEN         = 64,
  parameter logic [63:0] RESET_VECTOR = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            jump_valid,
  input  logic            jump_kind,
  input  logic [XLEN-1:0] jump_base,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  output logic            misalign
`ifdef PC_GEN_RVC_EN
  ,
  input  logic            inst_len2
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] RST_PC   = RESET_VECTOR[XLEN-1:0];
  localparam logic [XLEN-1:0] LSB_CLR  = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] STEP4    = {{(XLEN-3){1'b0}}, 3'd4};
`ifdef PC_GEN_RVC_EN
  localparam logic [XLEN-1:0] STEP2    = {{(XLEN-2){1'b0}}, 2'd2};
`endif

  // Low two target bits decide whether a jump lands on a legal instruction boundary.
  function automatic logic is_misaligned(input logic [1:0] lo);
`ifdef PC_GEN_RVC_EN
    return (lo & 2'b01) != 2'b00;
`else
    return lo != 2'b00;
`endif
  endfunction

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pend_tgt_q, pend_tgt_d;
  logic              pend_trap_q, pend_trap_d;
  logic              misalign_q, misalign_d;

  logic [XLEN-1:0]   jump_tgt_s;
  logic              jump_bad_s;
  logic              redir_valid_s;
  logic              redir_trap_s;
  logic [XLEN-1:0]   redir_tgt_s;
  logic              fetch_valid_s;
  logic              hs_s;
  logic              advance_s;
  logic              take_new_s;
  logic [XLEN-1:0]   step_s;

  // Decode the incoming redirect: trap wins, misaligned jumps are dropped.
  always_comb begin
    if (jump_kind) begin
      jump_tgt_s = (rs1 + imm) & LSB_CLR;
    end else begin
      jump_tgt_s = jump_base + imm;
    end
    jump_bad_s    = is_misaligned(jump_tgt_s[1:0]);
    redir_trap_s  = trap_valid;
    redir_valid_s = trap_valid | (jump_valid & ~jump_bad_s);
    if (trap_valid) begin
      redir_tgt_s = trap_vec;
    end else begin
      redir_tgt_s = jump_tgt_s;
    end
`ifdef PC_GEN_RVC_EN
    if (inst_len2) begin
      step_s = STEP2;
    end else begin
      step_s = STEP4;
    end
`else
    step_s = STEP4;
`endif
    fetch_valid_s = (state_q != ST_BOOT) & ~stall;
    hs_s          = fetch_valid_s & fetch_ready;
    // The PC may move only when nothing is being offered or the offer is taken.
    advance_s     = ~fetch_valid_s | fetch_ready;
  end

  // Next-state, next-PC and pending-redirect bookkeeping.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_tgt_d  = pend_tgt_q;
    pend_trap_d = pend_trap_q;
    misalign_d  = 1'b0;
    take_new_s  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        misalign_d = jump_valid & ~trap_valid & jump_bad_s;
        if (redir_valid_s) begin
          if (advance_s) begin
            pc_d = redir_tgt_s;
          end else begin
            pend_tgt_d  = redir_tgt_s;
            pend_trap_d = redir_trap_s;
            state_d     = ST_PEND;
          end
        end else if (hs_s) begin
          pc_d = pc_q + step_s;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_PEND: begin
        misalign_d = jump_valid & ~trap_valid & jump_bad_s;
        // A buffered trap is never displaced by a later jump.
        take_new_s = redir_valid_s & (redir_trap_s | ~pend_trap_q);
        if (take_new_s) begin
          pend_tgt_d  = redir_tgt_s;
          pend_trap_d = redir_trap_s;
        end else begin
          pend_tgt_d  = pend_tgt_q;
          pend_trap_d = pend_trap_q;
        end
        if (advance_s) begin
          if (take_new_s) begin
            pc_d = redir_tgt_s;
          end else begin
            pc_d = pend_tgt_q;
          end
          pend_trap_d = 1'b0;
          state_d     = ST_RUN;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RST_PC;
      pend_tgt_q  <= {XLEN{1'b0}};
      pend_trap_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_trap_q <= pend_trap_d;
      misalign_q  <= misalign_d;
    end
  end

  assign fetch_valid = fetch_valid_s;
  assign fetch_pc    = pc_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a slot-level reference model predicts each cycle's PC, valid and misalign.
module tb_pc_gen;

  localparam logic [63:0] RV = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0, fetch_ready = 1'b0, jump_valid = 1'b0, jump_kind = 1'b0;
  logic        trap_valid = 1'b0, inst_len2 = 1'b0;
  logic [63:0] jump_base = 64'd0, rs1 = 64'd0, imm = 64'd0, trap_vec = 64'd0;
  logic        fetch_valid, misalign;
  logic [63:0] fetch_pc;
  logic        fv32, mis32;
  logic [31:0] pc32;
  logic [31:0] zero32 = 32'd0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(64), .RESET_VECTOR(RV)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_pc(fetch_pc), .jump_valid(jump_valid),
    .jump_kind(jump_kind), .jump_base(jump_base), .rs1(rs1), .imm(imm),
    .trap_valid(trap_valid), .trap_vec(trap_vec), .misalign(misalign)
`ifdef PC_GEN_RVC_EN
    , .inst_len2(inst_len2)
`endif
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(64'h0000_0000_FFFF_FFF8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .fetch_valid(fv32),
    .fetch_ready(1'b1), .fetch_pc(pc32), .jump_valid(1'b0),
    .jump_kind(1'b0), .jump_base(zero32), .rs1(zero32), .imm(zero32),
    .trap_valid(1'b0), .trap_vec(zero32), .misalign(mis32)
`ifdef PC_GEN_RVC_EN
    , .inst_len2(1'b0)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [63:0] pc; logic valid; logic mis;} obs_t;
  typedef struct {logic [63:0] tgt; bit trap;} redir_t;

  obs_t   exp_q[$];
  redir_t pend_q[$];
  logic [63:0] m_pc = RV;
  bit          m_boot = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected observation per clock edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fetch_pc", fetch_pc, e.pc);
        check("fetch_valid", {63'd0, fetch_valid}, {63'd0, e.valid});
        check("misalign", {63'd0, misalign}, {63'd0, e.mis});
      end
    end
  end

  // 32-bit instance: sequential wrap from FFFF_FFF8 after the first reset release.
  initial begin
    logic [31:0] exp32 [4];
    exp32[0] = 32'hFFFF_FFF8; exp32[1] = 32'hFFFF_FFFC;
    exp32[2] = 32'h0000_0000; exp32[3] = 32'h0000_0004;
    wait (rst_n === 1'b0);
    wait (rst_n === 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #3;
      check("pc32", {32'd0, pc32}, {32'd0, exp32[i]});
      check("valid32", {63'd0, fv32 & ~mis32}, 64'd1);
    end
  end

  // Apply inputs for this cycle and advance the reference model across the coming edge.
  task automatic drive_step(input bit st, input bit rd, input bit jv, input bit jk,
                            input logic [63:0] jb, input logic [63:0] r1, input logic [63:0] im,
                            input bit tv, input logic [63:0] tvec, input bit l2);
    bit fv, hs, bad, have_new;
    logic [63:0] tgt, step;
    redir_t nr;
    obs_t o;
    stall = st; fetch_ready = rd; jump_valid = jv; jump_kind = jk;
    jump_base = jb; rs1 = r1; imm = im; trap_valid = tv; trap_vec = tvec; inst_len2 = l2;
    fv = !m_boot && !st;
    hs = fv && rd;
    o.mis = 1'b0;
`ifdef PC_GEN_RVC_EN
    step = l2 ? 64'd2 : 64'd4;
`else
    step = 64'd4;
`endif
    if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      tgt = jk ? ((r1 + im) & ~64'd1) : (jb + im);
`ifdef PC_GEN_RVC_EN
      bad = tgt[0];
`else
      bad = (tgt % 64'd4) != 64'd0;
`endif
      o.mis = jv && !tv && bad;
      have_new = 1'b0;
      if (tv) begin
        nr.tgt = tvec; nr.trap = 1'b1; have_new = 1'b1;
      end else if (jv && !bad) begin
        nr.tgt = tgt; nr.trap = 1'b0; have_new = 1'b1;
      end
      if (pend_q.size() > 0) begin
        if (have_new && (nr.trap || !pend_q[0].trap)) pend_q[0] = nr;
        if (hs || !fv) begin
          m_pc = pend_q[0].tgt;
          pend_q.delete();
        end
      end else if (have_new) begin
        if (hs || !fv) m_pc = nr.tgt;
        else pend_q.push_back(nr);
      end else if (hs) begin
        m_pc = m_pc + step;
      end
    end
    o.pc = m_pc;
    o.valid = !m_boot && !st;
    exp_q.push_back(o);
  endtask

  task automatic cyc(input bit st, input bit rd, input bit jv, input bit jk,
                     input logic [63:0] jb, input logic [63:0] r1, input logic [63:0] im,
                     input bit tv, input logic [63:0] tvec);
    @(negedge clk);
    drive_step(st, rd, jv, jk, jb, r1, im, tv, tvec, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0);
  endtask

  // Async reset mid-cycle, then release into one BOOT cycle.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_pc", fetch_pc, RV);
    check("rst_valid", {63'd0, fetch_valid}, 64'd0);
    check("rst_misalign", {63'd0, misalign}, 64'd0);
    exp_q.delete();
    pend_q.delete();
    m_pc = RV;
    m_boot = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_step(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0);
    #1;
    check("boot_valid", {63'd0, fetch_valid}, 64'd0);
    check("boot_pc", fetch_pc, RV);
  endtask

  initial begin
    logic [63:0] b, r, im, tvv;
    bit st, rd, jv, jk, tv, l2;
    do_reset();
    idle(4);
    // Redirect while the offered PC is held by ~ready.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0008, 64'd0, 64'h40, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0);
    idle(2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 64'd0, 64'h1003, 64'd1, 1'b0, 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 64'd0, 64'h1001, 64'd1, 1'b0, 64'd0);
    idle(2);
    // Trap beats a simultaneous jump; a buffered trap survives a later jump.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h200, 64'd0, 64'd0, 1'b1, 64'h100);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b1, 64'h300);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h400, 64'd0, 64'd0, 1'b0, 64'd0);
    idle(2);
    // Wrap at the top of the address space.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd4, 1'b0, 64'd0);
    idle(3);
    // Reset while a redirect is pending.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h500, 64'd0, 64'd0, 1'b0, 64'd0);
    do_reset();
    idle(3);
    for (int i = 0; i < 2000; i++) begin
      if (i % 500 == 499) begin
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h700, 64'd0, 64'd0, 1'b0, 64'd0);
        do_reset();
      end
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) < 7);
      jv  = ($urandom_range(0, 9) < 3);
      jk  = $urandom_range(0, 1);
      tv  = ($urandom_range(0, 9) == 0);
      l2  = $urandom_range(0, 1);
      b   = {$urandom, $urandom} & ~64'd3;
      r   = {$urandom, $urandom};
      im  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) im = im & ~64'd3;
      tvv = {$urandom, $urandom} & ~64'd3;
      @(negedge clk);
      drive_step(st, rd, jv, jk, b, r, im, tv, tvv, l2);
    end
    @(posedge clk);
    #2;
    check("drain", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
